// File: rtl/vga_timing_if.sv
// Raster timing bundle: the control inputs of the timing generator and the
// counters/strobes it produces. The generator is the master; the pixel
// pipeline or bench that paces itself from the raster is the slave.
interface vga_timing_if;
    logic        en;
    logic        restart;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        vga_dv_o;
    logic        vga_hs_o;
    logic        vga_vs_o;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  en,
        input  restart,
        output h_cnt,
        output v_cnt,
        output vga_dv_o,
        output vga_hs_o,
        output vga_vs_o,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output en,
        output restart,
        input  h_cnt,
        input  v_cnt,
        input  vga_dv_o,
        input  vga_hs_o,
        input  vga_vs_o,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Video raster timing generator. Produces the h/v counters and the DV/HS/VS
// strobes plus line/frame start pulses and a completed-frame counter.
// Every strobe is decoded from the *next* counter values and registered in
// the same edge as the counters, so strobes and counters are never skewed.
// Defaults: VESA 1600x900@60 reduced blanking (108 MHz pixel clock).
module vga_timing_gen #(
    parameter int HRES   = 1600,
    parameter int HFP    = 24,
    parameter int HSYNC  = 80,
    parameter int HBP    = 96,
    parameter int VRES   = 900,
    parameter int VFP    = 1,
    parameter int VSYNC  = 3,
    parameter int VBP    = 96,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  bus
);
    localparam int HTOT = HRES + HFP + HSYNC + HBP;
    localparam int VTOT = VRES + VFP + VSYNC + VBP;

    // Counters are 11 bits wide, so the raster must fit in 2048x2048.
    if ((HTOT > 2048) || (VTOT > 2048)) begin : g_size_check
        $error("vga_timing_gen: HTOT/VTOT must not exceed 2048");
    end

    localparam logic [10:0] H_LAST   = 11'(HTOT - 1);
    localparam logic [10:0] V_LAST   = 11'(VTOT - 1);
    localparam logic [10:0] H_ACT    = 11'(HRES);
    localparam logic [10:0] V_ACT    = 11'(VRES);
    localparam logic [10:0] H_SYNC_S = 11'(HRES + HFP);
    localparam logic [10:0] H_SYNC_E = 11'(HRES + HFP + HSYNC);
    localparam logic [10:0] V_SYNC_S = 11'(VRES + VFP);
    localparam logic [10:0] V_SYNC_E = 11'(VRES + VFP + VSYNC);
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    logic [10:0] h_cnt_reg, v_cnt_reg;
    logic [15:0] frame_cnt_reg;
    logic        dv_reg, hs_reg, vs_reg;
    logic        line_start_reg, frame_start_reg;
    // Cleared by reset: the counters sit at 0 but no pixel is on screen yet,
    // so the first enabled edge loads the origin instead of advancing past it.
    logic        pos_valid_reg;
    // Previous-cycle restart, so a held restart only pulses frame_start once.
    logic        restart_d_reg;

    logic [10:0] h_next, v_next;
    logic        update;
    logic        frame_inc;
    logic        pulse_ok;
    logic        dv_next, hs_next, vs_next;

    // Next raster position: restart beats enable, enable beats hold.
    always_comb begin
        h_next    = h_cnt_reg;
        v_next    = v_cnt_reg;
        frame_inc = 1'b0;
        update    = bus.restart | bus.en;
        pulse_ok  = 1'b0;
        if (bus.restart) begin
            h_next    = '0;
            v_next    = '0;
            // A restart landing on the natural frame wrap still counts that frame.
            frame_inc = bus.en && pos_valid_reg &&
                        (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
            pulse_ok  = !restart_d_reg;
        end else if (bus.en) begin
            pulse_ok = 1'b1;
            if (!pos_valid_reg) begin
                h_next = '0;
                v_next = '0;
            end else if (h_cnt_reg == H_LAST) begin
                h_next = '0;
                if (v_cnt_reg == V_LAST) begin
                    v_next    = '0;
                    frame_inc = 1'b1;
                end else begin
                    v_next = v_cnt_reg + 11'd1;
                end
            end else begin
                h_next = h_cnt_reg + 11'd1;
            end
        end
    end

    // Strobe decode by comparison on the next position, so any restart point
    // yields self-consistent sync levels.
    always_comb begin
        dv_next = (h_next < H_ACT) && (v_next < V_ACT);
        hs_next = ((h_next >= H_SYNC_S) && (h_next < H_SYNC_E)) ? HS_ON : ~HS_ON;
        vs_next = ((v_next >= V_SYNC_S) && (v_next < V_SYNC_E)) ? VS_ON : ~VS_ON;
    end

    // Register counters, strobes and pulses; pulses drop whenever nothing moves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            frame_cnt_reg   <= '0;
            dv_reg          <= 1'b0;
            hs_reg          <= ~HS_ON;
            vs_reg          <= ~VS_ON;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            pos_valid_reg   <= 1'b0;
            restart_d_reg   <= 1'b0;
        end else begin
            restart_d_reg <= bus.restart;
            if (update) begin
                h_cnt_reg     <= h_next;
                v_cnt_reg     <= v_next;
                dv_reg        <= dv_next;
                hs_reg        <= hs_next;
                vs_reg        <= vs_next;
                pos_valid_reg <= 1'b1;
            end
            line_start_reg  <= update && pulse_ok && (h_next == 11'd0);
            frame_start_reg <= update && pulse_ok && (h_next == 11'd0) && (v_next == 11'd0);
            if (frame_inc) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.h_cnt       = h_cnt_reg;
    assign bus.v_cnt       = v_cnt_reg;
    assign bus.vga_dv_o    = dv_reg;
    assign bus.vga_hs_o    = hs_reg;
    assign bus.vga_vs_o    = vs_reg;
    assign bus.line_start  = line_start_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster (28x16 clocks) so many whole
// frames fit in the run, two instances with opposite sync polarity, random
// enable/restart/reset stimulus, and a reference model that tracks the raster
// as a single linear pixel index within the frame.
module tb_vga_timing_gen;
    localparam int HRES  = 16;
    localparam int HFP   = 3;
    localparam int HSYNC = 4;
    localparam int HBP   = 5;
    localparam int VRES  = 10;
    localparam int VFP   = 1;
    localparam int VSYNC = 2;
    localparam int VBP   = 3;
    localparam int HTOT  = HRES + HFP + HSYNC + HBP;
    localparam int VTOT  = VRES + VFP + VSYNC + VBP;
    localparam int FTOT  = HTOT * VTOT;
    localparam int NCYC  = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic restart = 1'b0;

    always #5 clk = ~clk;

    vga_timing_if bus_a ();
    vga_timing_if bus_b ();

    assign bus_a.en      = en;
    assign bus_a.restart = restart;
    assign bus_b.en      = en;
    assign bus_b.restart = restart;

    vga_timing_gen #(
        .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .HS_POL(1), .VS_POL(1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    vga_timing_gen #(
        .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .HS_POL(0), .VS_POL(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    int n_checks = 0;
    int n_failures = 0;

    // Reference model state: pixel index in frame, frames completed.
    bit          m_started;
    int          m_pos;
    logic [15:0] m_frames;
    bit          m_prev_restart;
    bit          m_ls;
    bit          m_fs;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_failures++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge with the current inputs.
    task automatic model_step();
        if (!rst) begin
            m_started      = 1'b0;
            m_pos          = 0;
            m_frames       = '0;
            m_prev_restart = 1'b0;
            m_ls           = 1'b0;
            m_fs           = 1'b0;
        end else if (restart) begin
            if (en && m_started && (m_pos == FTOT - 1))
                m_frames = m_frames + 16'd1;
            m_pos          = 0;
            m_started      = 1'b1;
            m_ls           = !m_prev_restart;
            m_fs           = !m_prev_restart;
            m_prev_restart = 1'b1;
        end else begin
            m_prev_restart = 1'b0;
            if (en) begin
                if (!m_started) begin
                    m_pos     = 0;
                    m_started = 1'b1;
                end else if (m_pos == FTOT - 1) begin
                    m_pos    = 0;
                    m_frames = m_frames + 16'd1;
                end else begin
                    m_pos = m_pos + 1;
                end
                m_ls = ((m_pos % HTOT) == 0);
                m_fs = (m_pos == 0);
            end else begin
                m_ls = 1'b0;
                m_fs = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string who, input bit pol,
                                 input logic [10:0] h, input logic [10:0] v,
                                 input logic dv, input logic hs, input logic vs,
                                 input logic ls, input logic fs, input logic [15:0] fc);
        int eh, ev;
        bit edv, ehs, evs;
        eh  = m_pos % HTOT;
        ev  = m_pos / HTOT;
        edv = m_started && (eh < HRES) && (ev < VRES);
        ehs = m_started && (eh >= HRES + HFP) && (eh < HRES + HFP + HSYNC);
        evs = m_started && (ev >= VRES + VFP) && (ev < VRES + VFP + VSYNC);
        check({who, ".h_cnt"},       32'(h),  32'(eh));
        check({who, ".v_cnt"},       32'(v),  32'(ev));
        check({who, ".dv"},          32'(dv), 32'(edv));
        check({who, ".hs"},          32'(hs), 32'(pol ? ehs : !ehs));
        check({who, ".vs"},          32'(vs), 32'(pol ? evs : !evs));
        check({who, ".line_start"},  32'(ls), 32'(m_ls));
        check({who, ".frame_start"}, 32'(fs), 32'(m_fs));
        check({who, ".frame_cnt"},   32'(fc), 32'(m_frames));
    endtask

    initial begin
        int restart_left;
        int wrap_restarts;
        restart_left  = 0;
        wrap_restarts = 0;
        rst     = 1'b0;
        en      = 1'b0;
        restart = 1'b0;
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs("a", 1'b1, bus_a.h_cnt, bus_a.v_cnt, bus_a.vga_dv_o, bus_a.vga_hs_o,
                          bus_a.vga_vs_o, bus_a.line_start, bus_a.frame_start, bus_a.frame_cnt);
            check_outputs("b", 1'b0, bus_b.h_cnt, bus_b.v_cnt, bus_b.vga_dv_o, bus_b.vga_hs_o,
                          bus_b.vga_vs_o, bus_b.line_start, bus_b.frame_start, bus_b.frame_cnt);
            if (n_failures > 40) break;
            if (m_fs && rst)
                $display("frame_start cyc=%0d frame_cnt=%0d restart=%0b", cyc, m_frames, restart);

            // Choose the inputs for the next edge.
            rst = (cyc < 3) ? 1'b0 : ($urandom_range(0, 999) != 0);
            if (cyc < 3 * FTOT) begin
                // Clean free-running start: several whole frames.
                en      = 1'b1;
                restart = 1'b0;
            end else if (restart_left > 0) begin
                restart      = 1'b1;
                restart_left = restart_left - 1;
                en           = ($urandom_range(0, 1) == 1);
            end else if (m_started && (m_pos == FTOT - 1) && ($urandom_range(0, 3) == 0)) begin
                restart = 1'b1;
                en      = 1'b1;
                wrap_restarts++;
                $display("restart on frame wrap cyc=%0d frame_cnt=%0d", cyc, m_frames);
            end else if ($urandom_range(0, 199) == 0) begin
                restart      = 1'b1;
                restart_left = $urandom_range(0, 3);
                en           = ($urandom_range(0, 1) == 1);
            end else begin
                restart = 1'b0;
                en      = ($urandom_range(0, 99) < 85);
            end
            model_step();
        end
        $display("restarts on frame wrap: %0d", wrap_restarts);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule
